// File: rtl/fusion_mac_unit.sv
// fusion_mac_unit
// Runtime-reconfigurable bit-fusion multiply-accumulate element. One 8-bit
// activation/weight pair per beat is split into 1 (8b), 2 (4b) or 4 (2b)
// lanes. Each lane multiplies, then accumulates over a tile of cfg_len beats
// on top of a bias sampled on the first beat. Two pipeline stages:
// product register, then accumulator.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready        tile configuration handshake (IDLE only)
//   cfg_mode                   00=8b, 01=4b, 10=2b, 11 treated as 8b
//   cfg_s_in, cfg_s_weight     operand signedness
//   cfg_len                    beats per tile (0 behaves as 1)
//   in_valid/in_ready          beat handshake (ACCUM only)
//   in_data, weight            packed lane operands, lane 0 in the LSBs
//   psum_in                    per-lane bias, sampled on the first beat
//   out_valid/out_ready        tile result handshake (DONE only)
//   psum_out                   packed per-lane accumulators, registered
//   busy                       high whenever not IDLE
module fusion_mac_unit #(
    parameter int ACC_WIDTH = 24,
    parameter int LEN_WIDTH = 8,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [1:0]             cfg_mode,
    input  logic                   cfg_s_in,
    input  logic                   cfg_s_weight,
    input  logic [LEN_WIDTH-1:0]   cfg_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic [7:0]             weight,
    input  logic [4*ACC_WIDTH-1:0] psum_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*ACC_WIDTH-1:0] psum_out,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_8B = 2'b00;
    localparam logic [1:0] MODE_4B = 2'b01;
    localparam logic [1:0] MODE_2B = 2'b10;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t               state_reg, state_next;
    logic [1:0]           mode_reg;
    logic                 s_in_reg, s_w_reg;
    logic [LEN_WIDTH-1:0] len_reg, cnt_reg;
    logic                 v1_reg, first_reg;
    logic                 cfg_fire, in_fire, last_beat, first_beat;

    assign cfg_fire   = cfg_valid & cfg_ready;
    assign in_fire    = in_valid & in_ready;
    assign first_beat = (cnt_reg == '0);
    // len_reg is never 0, so len-1 is the index of the final beat
    assign last_beat  = (cnt_reg == len_reg - LEN_WIDTH'(1));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cfg_ready  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // lets the last beat drain through the accumulator stage
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tile configuration and beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= MODE_8B;
            s_in_reg <= 1'b0;
            s_w_reg  <= 1'b0;
            len_reg  <= LEN_WIDTH'(1);
            cnt_reg  <= '0;
        end else if (cfg_fire) begin
            mode_reg <= (cfg_mode == 2'b11) ? MODE_8B : cfg_mode;
            s_in_reg <= cfg_s_in;
            s_w_reg  <= cfg_s_weight;
            len_reg  <= (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
            cnt_reg  <= '0;
        end else if (in_fire) begin
            cnt_reg <= cnt_reg + LEN_WIDTH'(1);
        end
    end

    // Stage-1 qualifiers shared by all lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            first_reg <= 1'b0;
        end else begin
            v1_reg    <= in_fire;
            first_reg <= in_fire & first_beat;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
        logic signed [8:0]           a_8, w_8, a_4, w_4, a_2, w_2;
        logic signed [8:0]           a_ext, w_ext;
        logic                        lane_active;
        logic signed [16:0]          prod_w;
        logic signed [ACC_WIDTH-1:0] prod_lane, prod_reg, bias_reg, acc_reg;
        logic signed [ACC_WIDTH-1:0] base, acc_sum, acc_next, psum_reg;
        logic signed [ACC_WIDTH:0]   sum_ext;

        // Operand slices extended to a common 9-bit signed form so one
        // signed multiplier covers every mode and sign combination.
        if (gi == 0) begin : gen_op8
            assign a_8 = {s_in_reg & in_data[7], in_data};
            assign w_8 = {s_w_reg & weight[7], weight};
        end else begin : gen_op8_none
            assign a_8 = '0;
            assign w_8 = '0;
        end

        if (gi < 2) begin : gen_op4
            assign a_4 = {{5{s_in_reg & in_data[4*gi+3]}}, in_data[4*gi +: 4]};
            assign w_4 = {{5{s_w_reg & weight[4*gi+3]}}, weight[4*gi +: 4]};
        end else begin : gen_op4_none
            assign a_4 = '0;
            assign w_4 = '0;
        end

        assign a_2 = {{7{s_in_reg & in_data[2*gi+1]}}, in_data[2*gi +: 2]};
        assign w_2 = {{7{s_w_reg & weight[2*gi+1]}}, weight[2*gi +: 2]};

        always_comb begin
            a_ext       = a_8;
            w_ext       = w_8;
            lane_active = (gi == 0);
            case (mode_reg)
                MODE_4B: begin
                    a_ext       = a_4;
                    w_ext       = w_4;
                    lane_active = (gi < 2);
                end
                MODE_2B: begin
                    a_ext       = a_2;
                    w_ext       = w_2;
                    lane_active = 1'b1;
                end
                default: begin
                    a_ext       = a_8;
                    w_ext       = w_8;
                    lane_active = (gi == 0);
                end
            endcase
        end

        // Largest magnitude product is 255*255, which fits 17-bit signed.
        assign prod_w    = 17'(a_ext * w_ext);
        assign prod_lane = lane_active ? ACC_WIDTH'(prod_w) : '0;

        // Stage 1: product and (first beat only) bias
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_reg <= '0;
                bias_reg <= '0;
            end else if (in_fire) begin
                prod_reg <= prod_lane;
                if (first_beat) begin
                    bias_reg <= lane_active ? psum_in[ACC_WIDTH*gi +: ACC_WIDTH] : '0;
                end
            end
        end

        // Stage 2: accumulate with one guard bit for overflow detection
        assign base    = first_reg ? bias_reg : acc_reg;
        assign sum_ext = {base[ACC_WIDTH-1], base} + {prod_reg[ACC_WIDTH-1], prod_reg};

        always_comb begin
            acc_sum = sum_ext[ACC_WIDTH-1:0];
            if (SATURATE && (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1])) begin
                acc_sum = sum_ext[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
            end
        end

        assign acc_next = v1_reg ? acc_sum : acc_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_reg <= '0;
            end else begin
                acc_reg <= acc_next;
            end
        end

        // The final beat lands in acc_next during FLUSH, so capture it
        // directly rather than waiting a further cycle for acc_reg.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                psum_reg <= '0;
            end else if (state_reg == FLUSH) begin
                psum_reg <= lane_active ? acc_next : '0;
            end
        end

        assign psum_out[ACC_WIDTH*gi +: ACC_WIDTH] = psum_reg;
    end

endmodule

// File: tb/tb_fusion_mac_unit.sv
// Scoreboard bench for fusion_mac_unit. Three instances share one stimulus
// stream: 24-bit wrapping, 17-bit saturating and 17-bit wrapping. Expected
// per-lane tile results are pushed as plain integers; the monitor packs
// them for each instance's width (clamping for the saturating one).
module tb_fusion_mac_unit;

    typedef logic [3:0][31:0] lanes_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [1:0]  cfg_mode;
    logic        cfg_s_in, cfg_s_weight;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [7:0]  in_data, weight;
    logic        out_ready;

    lanes_t      bias_v;
    logic [95:0] psum_in_a;
    logic [67:0] psum_in_s;

    logic        cfg_ready_a, in_ready_a, out_valid_a, busy_a;
    logic [95:0] psum_out_a;
    logic        cfg_ready_s, in_ready_s, out_valid_s, busy_s;
    logic [67:0] psum_out_s;
    logic        cfg_ready_w, in_ready_w, out_valid_w, busy_w;
    logic [67:0] psum_out_w;

    int     checks = 0;
    int     errors = 0;
    int     n_out  = 0;
    lanes_t exp_q[$];

    always #5 clk = ~clk;

    fusion_mac_unit #(.ACC_WIDTH(24), .LEN_WIDTH(8), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a), .cfg_mode(cfg_mode),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .weight(weight),
        .psum_in(psum_in_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .psum_out(psum_out_a), .busy(busy_a)
    );

    fusion_mac_unit #(.ACC_WIDTH(17), .LEN_WIDTH(8), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s), .cfg_mode(cfg_mode),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .weight(weight),
        .psum_in(psum_in_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .psum_out(psum_out_s), .busy(busy_s)
    );

    fusion_mac_unit #(.ACC_WIDTH(17), .LEN_WIDTH(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_w), .cfg_mode(cfg_mode),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .weight(weight),
        .psum_in(psum_in_s), .out_valid(out_valid_w), .out_ready(out_ready),
        .psum_out(psum_out_w), .busy(busy_w)
    );

    function automatic logic [95:0] pack24(lanes_t v);
        logic [95:0] r;
        for (int i = 0; i < 4; i++) r[24*i +: 24] = v[i][23:0];
        return r;
    endfunction

    function automatic logic [67:0] pack17(lanes_t v);
        logic [67:0] r;
        for (int i = 0; i < 4; i++) r[17*i +: 17] = v[i][16:0];
        return r;
    endfunction

    function automatic lanes_t clamp17(lanes_t v);
        lanes_t r;
        for (int i = 0; i < 4; i++) begin
            int x;
            x = v[i];
            if (x > 65535) x = 65535;
            else if (x < -65536) x = -65536;
            r[i] = x;
        end
        return r;
    endfunction

    always_comb begin
        psum_in_a = pack24(bias_v);
        psum_in_s = pack17(bias_v);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic set_bias(input int b0, input int b1, input int b2, input int b3);
        bias_v[0] = b0; bias_v[1] = b1; bias_v[2] = b2; bias_v[3] = b3;
    endtask

    task automatic expect_tile(input int l0, input int l1, input int l2, input int l3);
        lanes_t v;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        exp_q.push_back(v);
    endtask

    task automatic do_cfg(input logic [1:0] m, input logic si, input logic sw, input logic [7:0] len);
        @(negedge clk);
        in_valid     = 1'b0;
        cfg_valid    = 1'b1;
        cfg_mode     = m;
        cfg_s_in     = si;
        cfg_s_weight = sw;
        cfg_len      = len;
    endtask

    task automatic do_beat(input logic [7:0] d, input logic [7:0] w);
        @(negedge clk);
        cfg_valid = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        weight    = w;
    endtask

    task automatic do_gap();
        @(negedge clk);
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'hA5;
        weight    = 8'h5A;
    endtask

    // Last beat was issued by the caller; checks FLUSH then DONE timing.
    task automatic finish_tile(input string name);
        @(negedge clk);
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        check({name, "_flush_valid"}, 128'(out_valid_a), 128'd0);
        @(negedge clk);
        check({name, "_done_valid"}, 128'(out_valid_a), 128'd1);
        @(negedge clk);
    endtask

    // Monitor: samples between the stimulus edge and the active edge.
    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid_a && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got psum %h required no output", psum_out_a);
            end else begin
                lanes_t v;
                v = exp_q.pop_front();
                check("psum_acc24", 128'(psum_out_a), 128'(pack24(v)));
                check("psum_sat17", 128'(psum_out_s), 128'(pack17(clamp17(v))));
                check("psum_wrap17", 128'(psum_out_w), 128'(pack17(v)));
                check("valid_sync", 128'({out_valid_s, out_valid_w}), 128'd3);
                $display("tile %0d lanes %0d %0d %0d %0d psum24 %h", n_out,
                         $signed(v[0]), $signed(v[1]), $signed(v[2]), $signed(v[3]), psum_out_a);
                n_out++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_s_in = 1'b0;
        cfg_s_weight = 1'b0; cfg_len = 8'd1; in_valid = 1'b0; in_data = 8'h00;
        weight = 8'h00; out_ready = 1'b1;
        set_bias(0, 0, 0, 0);
        #1;
        check("rst_cfg_ready", 128'(cfg_ready_a), 128'd1);
        check("rst_busy", 128'(busy_a), 128'd0);
        check("rst_out_valid", 128'(out_valid_a), 128'd0);
        check("rst_in_ready", 128'(in_ready_a), 128'd0);
        check("rst_psum", 128'(psum_out_a), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 8b signed: -3*5 + 10, inactive-lane bias discarded
        set_bias(10, 7, 7, 7);
        expect_tile(-5, 0, 0, 0);
        do_cfg(2'b00, 1'b1, 1'b1, 8'd1);
        do_beat(8'hFD, 8'h05);
        finish_tile("s8");

        // Reset in the middle of a 4-beat tile
        set_bias(0, 0, 0, 0);
        do_cfg(2'b00, 1'b0, 1'b0, 8'd4);
        do_beat(8'h11, 8'h11);
        do_beat(8'h22, 8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid_a), 128'd0);
        check("midrst_cfg_ready", 128'(cfg_ready_a), 128'd1);
        check("midrst_busy", 128'(busy_a), 128'd0);
        check("midrst_psum24", 128'(psum_out_a), 128'd0);
        check("midrst_psum17", 128'({psum_out_s, psum_out_w}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 11 behaves as 8b unsigned: 195*2 + 7
        set_bias(7, 5, 5, 5);
        expect_tile(397, 0, 0, 0);
        do_cfg(2'b11, 1'b0, 1'b0, 8'd1);
        do_beat(8'hC3, 8'h02);
        finish_tile("m11");

        // 4b unsigned, 3 beats with gaps
        set_bias(0, 0, 99, 99);
        expect_tile(45, 18, 0, 0);
        do_cfg(2'b01, 1'b0, 1'b0, 8'd3);
        do_beat(8'h3F, 8'h21);
        do_gap();
        do_gap();
        do_beat(8'h3F, 8'h21);
        do_gap();
        do_beat(8'h3F, 8'h21);
        finish_tile("u4gap");

        // Same tile without gaps
        expect_tile(45, 18, 0, 0);
        do_cfg(2'b01, 1'b0, 1'b0, 8'd3);
        do_beat(8'h3F, 8'h21);
        do_beat(8'h3F, 8'h21);
        do_beat(8'h3F, 8'h21);
        finish_tile("u4");

        // 2b signed, len 0 acts as a single beat
        set_bias(0, 0, 0, 0);
        expect_tile(0, 1, -2, -1);
        do_cfg(2'b10, 1'b1, 1'b1, 8'd0);
        do_beat(8'hE4, 8'h55);
        finish_tile("s2");

        // 5 x 127*127 = 80645: fits 24b, clamps at 17b sat, wraps at 17b
        expect_tile(80645, 0, 0, 0);
        do_cfg(2'b00, 1'b1, 1'b1, 8'd5);
        for (int i = 0; i < 5; i++) do_beat(8'h7F, 8'h7F);
        finish_tile("sat");

        // Output backpressure in DONE
        set_bias(100, -50, 9, 9);
        expect_tile(70, -51, 0, 0);
        out_ready = 1'b0;
        do_cfg(2'b01, 1'b1, 1'b1, 8'd2);
        do_beat(8'hF7, 8'h3E);
        do_beat(8'h18, 8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        begin
            lanes_t bp;
            bp[0] = 70; bp[1] = -51; bp[2] = 0; bp[3] = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                in_valid  = 1'b1;
                in_data   = 8'hFF;
                weight    = 8'hFF;
                cfg_valid = 1'b1;
                cfg_mode  = 2'b10;
                cfg_len   = 8'd3;
                check("bp_out_valid", 128'(out_valid_a), 128'd1);
                check("bp_cfg_ready", 128'(cfg_ready_a), 128'd0);
                check("bp_in_ready", 128'(in_ready_a), 128'd0);
                check("bp_psum_stable", 128'(psum_out_a), 128'(pack24(bp)));
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp_idle_cfg_ready", 128'(cfg_ready_a), 128'd1);
        check("bp_idle_busy", 128'(busy_a), 128'd0);
        repeat (3) @(negedge clk);
        check("bp_no_latch", 128'({cfg_ready_a, busy_a}), 128'd2);

        repeat (4) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        check("tiles_out", 128'(n_out), 128'd7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
